guess_game_ctrl: RTL and testbench

- Game sequencer for the guess-the-number datapath.
- Samples a free-running 6-bit LFSR value as the secret when a round starts, then accepts player guesses through a valid/ready handshake.
- Grades each guess as low, high or correct, and counts attempts up to a limit.
- Sits between the LFSR, the board input logic (switches/buttons, already debounced and one-cycle pulsed) and the display/LED drivers.

---
 rtl/guess_game_ctrl.sv | 141 ++++++++++++++
 tb/tb_guess_game_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl: round sequencer for the guess-the-number datapath.
//
// Captures a folded LFSR sample as the secret when a round starts. Accepts
// guesses through a valid/ready handshake, grades each one as low, high or
// correct, and counts attempts up to MAX_TRIES.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   rnd_in       LFSR sample, captured only on start
//   start        one-cycle pulse, begins (or restarts) a round
//   guess        player guess
//   guess_valid  guess present this cycle
//   guess_ready  high only while playing
//   too_low      last accepted guess was below the secret
//   too_high     last accepted guess was above the secret
//   bad_guess    one-cycle pulse, an out-of-range guess was rejected
//   tries        accepted guesses this round
//   win / lose   round outcome levels
//   secret_out   revealed secret (zero unless GUESS_REVEAL_EN is defined)
//
// Optional build macro: GUESS_REVEAL_EN exposes the secret in WIN/LOSE.
module guess_game_ctrl #(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned MAX_VALUE = 63,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rnd_in,
    input  logic             start,
    input  logic [WIDTH-1:0] guess,
    input  logic             guess_valid,
    output logic             guess_ready,
    output logic             too_low,
    output logic             too_high,
    output logic             bad_guess,
    output logic [3:0]       tries,
    output logic             win,
    output logic             lose,
    output logic [WIDTH-1:0] secret_out
);

    typedef enum logic [1:0] {StIdle, StPlay, StWin, StLose} state_e;

    localparam logic [WIDTH-1:0] MaxVal     = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH:0]   WrapVal    = (WIDTH + 1)'(MAX_VALUE + 1);
    localparam logic [3:0]       TriesLimit = 4'(MAX_TRIES);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] secret_q, secret_d;
    logic [3:0]       tries_q, tries_d;
    logic             too_low_q, too_low_d;
    logic             too_high_q, too_high_d;
    logic             bad_q, bad_d;

    logic             rnd_over;
    logic             guess_over;
    logic [WIDTH-1:0] rnd_folded;

    // When MAX_VALUE spans the full range nothing can be out of range; tie off
    // rather than emit a comparison that is constant.
    if (MAX_VALUE >= (2 ** WIDTH) - 1) begin : g_full_range
        assign rnd_over   = 1'b0;
        assign guess_over = 1'b0;
    end else begin : g_part_range
        assign rnd_over   = (rnd_in > MaxVal);
        assign guess_over = (guess > MaxVal);
    end

    // Out-of-range samples wrap back into 0..MAX_VALUE; a single subtraction
    // suffices because MAX_VALUE is at least half the sample range.
    assign rnd_folded = rnd_over ? WIDTH'({1'b0, rnd_in} - WrapVal) : rnd_in;

    always_comb begin
        state_d    = state_q;
        secret_d   = secret_q;
        tries_d    = tries_q;
        too_low_d  = too_low_q;
        too_high_d = too_high_q;
        bad_d      = 1'b0;

        if (start) begin
            // Start wins over any simultaneous guess, which is dropped.
            state_d    = StPlay;
            secret_d   = rnd_folded;
            tries_d    = 4'd0;
            too_low_d  = 1'b0;
            too_high_d = 1'b0;
        end else if ((state_q == StPlay) && guess_valid) begin
            if (guess_over) begin
                bad_d = 1'b1;
            end else if (guess == secret_q) begin
                tries_d    = tries_q + 4'd1;
                too_low_d  = 1'b0;
                too_high_d = 1'b0;
                state_d    = StWin;
            end else begin
                tries_d    = tries_q + 4'd1;
                too_low_d  = (guess < secret_q);
                too_high_d = (guess > secret_q);
                if ((tries_q + 4'd1) == TriesLimit) begin
                    state_d = StLose;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            secret_q   <= '0;
            tries_q    <= 4'd0;
            too_low_q  <= 1'b0;
            too_high_q <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            secret_q   <= secret_d;
            tries_q    <= tries_d;
            too_low_q  <= too_low_d;
            too_high_q <= too_high_d;
            bad_q      <= bad_d;
        end
    end

    assign guess_ready = (state_q == StPlay);
    assign win         = (state_q == StWin);
    assign lose        = (state_q == StLose);
    assign too_low     = too_low_q;
    assign too_high    = too_high_q;
    assign bad_guess   = bad_q;
    assign tries       = tries_q;

`ifdef GUESS_REVEAL_EN
    assign secret_out = ((state_q == StWin) || (state_q == StLose)) ? secret_q : '0;
`else
    assign secret_out = '0;
`endif

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Self-checking bench for guess_game_ctrl: two instances (default and
// MAX_VALUE=40/MAX_TRIES=5) share stimulus and are checked every cycle
// against a behavioural game model, plus literal spot checks.
module tb_guess_game_ctrl;

    localparam logic [1:0] PIdle = 2'd0;
    localparam logic [1:0] PPlay = 2'd1;
    localparam logic [1:0] PWin  = 2'd2;
    localparam logic [1:0] PLose = 2'd3;

    typedef struct packed {
        logic [1:0] phase;
        logic [5:0] secret;
        logic [3:0] tries;
        logic       low;
        logic       high;
        logic       bad;
    } model_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] rnd_in;
    logic       start;
    logic [5:0] guess;
    logic       guess_valid;

    logic       ready0, low0, high0, bad0, win0, lose0;
    logic [3:0] tries0;
    logic [5:0] sec0;
    logic       ready1, low1, high1, bad1, win1, lose1;
    logic [3:0] tries1;
    logic [5:0] sec1;

    int     total = 0;
    int     bad   = 0;
    bit     check_en = 1'b0;
    model_t m0 = '0;
    model_t m1 = '0;

    always #5 clk = ~clk;

    guess_game_ctrl u_dut0 (
        .clk(clk), .reset(reset), .rnd_in(rnd_in), .start(start), .guess(guess),
        .guess_valid(guess_valid), .guess_ready(ready0), .too_low(low0), .too_high(high0),
        .bad_guess(bad0), .tries(tries0), .win(win0), .lose(lose0), .secret_out(sec0)
    );

    guess_game_ctrl #(.WIDTH(6), .MAX_VALUE(40), .MAX_TRIES(5)) u_dut1 (
        .clk(clk), .reset(reset), .rnd_in(rnd_in), .start(start), .guess(guess),
        .guess_valid(guess_valid), .guess_ready(ready1), .too_low(low1), .too_high(high1),
        .bad_guess(bad1), .tries(tries1), .win(win1), .lose(lose1), .secret_out(sec1)
    );

    // Game rules applied to one edge.
    function automatic model_t step(model_t m, int mv, int mt, bit rst, bit st, int rnd,
                                    int g, bit gv);
        model_t n = m;
        n.bad = 1'b0;
        if (rst) begin
            n = '0;
        end else if (st) begin
            n.phase  = PPlay;
            n.secret = (rnd <= mv) ? 6'(rnd) : 6'(rnd - (mv + 1));
            n.tries  = 4'd0;
            n.low    = 1'b0;
            n.high   = 1'b0;
        end else if (m.phase == PPlay && gv) begin
            if (g > mv) begin
                n.bad = 1'b1;
            end else begin
                n.tries = 4'(int'(m.tries) + 1);
                if (g == int'(m.secret)) begin
                    n.low   = 1'b0;
                    n.high  = 1'b0;
                    n.phase = PWin;
                end else begin
                    n.low  = (g < int'(m.secret));
                    n.high = (g > int'(m.secret));
                    if (int'(m.tries) + 1 == mt) n.phase = PLose;
                end
            end
        end
        return n;
    endfunction

    function automatic int exp_secret(model_t m);
`ifdef GUESS_REVEAL_EN
        return (m.phase == PWin || m.phase == PLose) ? int'(m.secret) : 0;
`else
        return 0;
`endif
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m0 <= step(m0, 63, 8, reset, start, int'(rnd_in), int'(guess), guess_valid);
        m1 <= step(m1, 40, 5, reset, start, int'(rnd_in), int'(guess), guess_valid);
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("ready0", int'(ready0), int'(m0.phase == PPlay));
            chk("win0", int'(win0), int'(m0.phase == PWin));
            chk("lose0", int'(lose0), int'(m0.phase == PLose));
            chk("low0", int'(low0), int'(m0.low));
            chk("high0", int'(high0), int'(m0.high));
            chk("bad0", int'(bad0), int'(m0.bad));
            chk("tries0", int'(tries0), int'(m0.tries));
            chk("secret_out0", int'(sec0), exp_secret(m0));
            chk("ready1", int'(ready1), int'(m1.phase == PPlay));
            chk("win1", int'(win1), int'(m1.phase == PWin));
            chk("lose1", int'(lose1), int'(m1.phase == PLose));
            chk("low1", int'(low1), int'(m1.low));
            chk("high1", int'(high1), int'(m1.high));
            chk("bad1", int'(bad1), int'(m1.bad));
            chk("tries1", int'(tries1), int'(m1.tries));
            chk("secret_out1", int'(sec1), exp_secret(m1));
        end
    end

    // Apply one cycle of inputs; returns just after the sampling edge.
    task automatic drive(bit rst, bit st, int r, int g, bit gv);
        reset       = rst;
        start       = st;
        rnd_in      = 6'(r);
        guess       = 6'(g);
        guess_valid = gv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        reset = 1'b1; start = 1'b0; rnd_in = '0; guess = '0; guess_valid = 1'b1;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        drive(1, 0, 0, 0, 1);
        chk("rst_ready", int'(ready0), 0);
        chk("rst_tries", int'(tries0), 0);
        chk("rst_win", int'(win0), 0);
        chk("rst_low", int'(low0), 0);

        // Secret 37, guesses 20, 50, 37.
        drive(0, 1, 37, 0, 0);
        chk("start_ready", int'(ready0), 1);
        drive(0, 0, 0, 20, 1);
        chk("g20_low", int'(low0), 1);
        drive(0, 0, 0, 50, 1);
        chk("g50_high", int'(high0), 1);
        drive(0, 0, 0, 37, 1);
        chk("g37_win", int'(win0), 1);
        chk("g37_tries", int'(tries0), 3);
        chk("g37_ready", int'(ready0), 0);
        chk("g37_win1", int'(win1), 1);

        // Eight misses of 0.
        drive(0, 1, 37, 0, 0);
        repeat (8) drive(0, 0, 0, 0, 1);
        chk("miss_lose", int'(lose0), 1);
        chk("miss_tries", int'(tries0), 8);
        chk("miss_low", int'(low0), 1);
        chk("miss_lose1", int'(lose1), 1);
        chk("miss_tries1", int'(tries1), 5);
`ifndef GUESS_REVEAL_EN
        chk("lose_hidden", int'(sec0), 0);
`endif
        drive(0, 0, 0, 0, 1);
        chk("ninth_tries", int'(tries0), 8);

        // Folded secret on the MAX_VALUE=40 instance: 50 -> 9.
        drive(0, 1, 50, 0, 0);
        drive(0, 0, 0, 45, 1);
        chk("g45_bad1", int'(bad1), 1);
        chk("g45_tries1", int'(tries1), 0);
        chk("g45_low0", int'(low0), 1);
        drive(0, 0, 0, 9, 1);
        chk("g9_win1", int'(win1), 1);
        chk("g9_bad1", int'(bad1), 0);

        // Start overrides a winning guess.
        drive(0, 1, 37, 0, 0);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 2, 1);
        chk("pre_tries", int'(tries0), 2);
        drive(0, 1, 10, 37, 1);
        chk("restart_tries", int'(tries0), 0);
        chk("restart_win", int'(win0), 0);
        chk("restart_ready", int'(ready0), 1);
        drive(0, 0, 0, 10, 1);
        chk("new_secret_win", int'(win0), 1);

        // Random play.
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0:       g = int'(m0.secret);
                1:       g = int'(m1.secret);
                default: g = int'($urandom_range(0, 63));
            endcase
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
                  int'($urandom_range(0, 63)), g, ($urandom_range(0, 9) < 7));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
